// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write queue.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned RIDX_W   = 4;

    // One queued register write; addr is the 4-bit register index.
    typedef struct packed {
        logic [RIDX_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

    // Addresses with the top bit set lie outside the 16-entry register file.
    function automatic logic addr_legal(input logic [RADDR_W-1:0] a);
        return !a[RADDR_W-1];
    endfunction

endpackage

// File: rtl/wq_fwd_lookup.sv
// Youngest-match search over the valid queue entries for one decode read port.
module wq_fwd_lookup
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  wq_entry_t          entries [DEPTH],
    input  logic [PTR_W-1:0]   rd_ptr,
    input  logic [CNT_W-1:0]   count,
    input  logic [RADDR_W-1:0] raddr,
    output logic               hit,
    output logic [DATA_W-1:0]  data
);

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && addr_legal(raddr) &&
                (entries[rd_ptr + PTR_W'(i)].addr == raddr[RIDX_W-1:0])) begin
                hit  = 1'b1;
                data = entries[rd_ptr + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue between the ALU / load unit and the register file write port,
// with forwarding of pending writes to the two decode read ports.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                mem_valid,
    input  logic [RADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                alu_valid,
    input  logic [RADDR_W-1:0]  alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    output logic                RegWr,
    output logic [RADDR_W-1:0]  Waddr,
    output logic [DATA_W-1:0]   Writedata,
    input  logic [RADDR_W-1:0]  Raddr1,
    input  logic [RADDR_W-1:0]  Raddr2,
    output logic                fwd_hit1,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic                fwd_hit2,
    output logic [DATA_W-1:0]   fwd_data2,
    output logic                bad_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wq_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             mem_take;
    logic             alu_take;
    logic             any_bad;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    wq_entry_t        head;

    // Handshake: ready depends only on registered count and the mem request, never on pop.
    always_comb begin
        mem_ready = (count < CNT_W'(DEPTH));
        mem_take  = mem_valid && mem_ready && addr_legal(mem_addr);
        alu_ready = ((count + CNT_W'(mem_take)) < CNT_W'(DEPTH));
        alu_take  = alu_valid && alu_ready && addr_legal(alu_addr);
        // Illegal requests are still consumed; they only raise the error pulse.
        any_bad   = (mem_valid && mem_ready && !addr_legal(mem_addr)) ||
                    (alu_valid && alu_ready && !addr_legal(alu_addr));
    end

    // Pointer and count next-state; the load lands ahead of the ALU result.
    always_comb begin
        pop         = (count != '0);
        alu_slot    = wr_ptr + PTR_W'(mem_take);
        wr_ptr_next = wr_ptr + PTR_W'(mem_take) + PTR_W'(alu_take);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        count_next  = count + CNT_W'(mem_take) + CNT_W'(alu_take) - CNT_W'(pop);
    end

    // Control state with synchronous reset; queued entries are simply abandoned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bad_addr <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            bad_addr <= any_bad;
        end
    end

    // Entry storage; data is not reset since count gates every use of it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (mem_take) begin
                entries[wr_ptr] <= '{addr: mem_addr[RIDX_W-1:0], data: mem_data};
            end
            if (alu_take) begin
                entries[alu_slot] <= '{addr: alu_addr[RIDX_W-1:0], data: alu_data};
            end
        end
    end

    // Drain port: the head entry is presented whenever the queue holds anything.
    always_comb begin
        head      = entries[rd_ptr];
        RegWr     = pop;
        Waddr     = '0;
        Writedata = '0;
        if (pop) begin
            Waddr     = {1'b0, head.addr};
            Writedata = head.data;
        end
    end

    wq_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .entries (entries),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .raddr   (Raddr1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wq_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .entries (entries),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .raddr   (Raddr2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a write-order scoreboard on the drain port.
module tb_regfile_write_queue;

    logic        CLK;
    logic        RESET;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        RegWr;
    logic [4:0]  Waddr;
    logic [31:0] Writedata;
    logic [4:0]  Raddr1;
    logic [4:0]  Raddr2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic        bad_addr;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    regfile_write_queue #(
        .DEPTH (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .RegWr     (RegWr),
        .Waddr     (Waddr),
        .Writedata (Writedata),
        .Raddr1    (Raddr1),
        .Raddr2    (Raddr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .bad_addr  (bad_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic idle();
        set_mem(1'b0, 5'd0, 32'd0);
        set_alu(1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Every committed write (outside reset) must be the oldest expected one.
    always @(negedge CLK) begin
        if (!RESET && RegWr) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'(Waddr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("drain_addr", 32'(Waddr), 32'(mon_e.a));
                check("drain_data", Writedata, mon_e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int m_cnt;
        int sent;
        logic mt;
        logic at;

        n_checks = 0;
        n_pass   = 0;
        RESET    = 1'b1;
        Raddr1   = 5'd0;
        Raddr2   = 5'd0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;

        // Reset state
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_waddr", 32'(Waddr), 32'd0);
        check("rst_wdata", Writedata, 32'd0);
        check("rst_hit1", 32'(fwd_hit1), 32'd0);
        check("rst_hit2", 32'(fwd_hit2), 32'd0);
        check("rst_data1", fwd_data1, 32'd0);
        check("rst_data2", fwd_data2, 32'd0);
        check("rst_bad", 32'(bad_addr), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);

        // Single ALU write, one cycle latency
        set_alu(1'b1, 5'd3, 32'hDEAD_BEEF);
        expect_wr(5'd3, 32'hDEAD_BEEF);
        #1;
        check("t1_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("t1_regwr", 32'(RegWr), 32'd1);
        check("t1_waddr", 32'(Waddr), 32'd3);
        check("t1_wdata", Writedata, 32'hDEAD_BEEF);
        tick();
        check("t1_regwr_after", 32'(RegWr), 32'd0);

        // Dual push to the same register: mem first, youngest forwarded
        set_mem(1'b1, 5'd5, 32'h11);
        set_alu(1'b1, 5'd5, 32'h22);
        expect_wr(5'd5, 32'h11);
        expect_wr(5'd5, 32'h22);
        Raddr2 = 5'd6;
        #1;
        check("t2_mem_ready", 32'(mem_ready), 32'd1);
        check("t2_alu_ready", 32'(alu_ready), 32'd1);
        check("t2_no_same_cycle_fwd", 32'(fwd_hit2), 32'd0);
        tick();
        idle();
        Raddr1 = 5'd5;
        #1;
        check("t2_wdata0", Writedata, 32'h11);
        check("t2_hit1", 32'(fwd_hit1), 32'd1);
        check("t2_fdata1", fwd_data1, 32'h22);
        check("t2_hit2_miss", 32'(fwd_hit2), 32'd0);
        check("t2_fdata2_miss", fwd_data2, 32'd0);
        tick();
        check("t2_wdata1", Writedata, 32'h22);
        check("t2_hit1_head", 32'(fwd_hit1), 32'd1);
        check("t2_fdata1_head", fwd_data1, 32'h22);
        tick();
        check("t2_regwr_done", 32'(RegWr), 32'd0);
        check("t2_hit1_done", 32'(fwd_hit1), 32'd0);
        Raddr1 = 5'd0;
        Raddr2 = 5'd0;

        // Back-to-back ALU results never see backpressure
        for (int i = 0; i < 5; i++) begin
            set_alu(1'b1, 5'(8 + i), 32'h300 + i);
            expect_wr(5'(8 + i), 32'h300 + i);
            #1;
            check("t3_alu_stream_ready", 32'(alu_ready), 32'd1);
            tick();
        end
        idle();
        tick();

        // Dual pushes every cycle until 10 entries are accepted
        m_cnt = 0;
        sent  = 0;
        for (int cyc = 0; cyc < 30 && sent < 10; cyc++) begin
            set_mem(sent < 10, 5'(cyc % 16), 32'h1000 + cyc);
            set_alu(sent < 9, 5'((cyc + 8) % 16), 32'h2000 + cyc);
            mt = mem_valid && (m_cnt < 4);
            at = alu_valid && ((m_cnt + int'(mt)) < 4);
            if (mt) expect_wr(mem_addr, mem_data);
            if (at) expect_wr(alu_addr, alu_data);
            #1;
            check("t3_mem_ready", 32'(mem_ready), 32'(m_cnt < 4));
            check("t3_alu_ready", 32'(alu_ready), 32'((m_cnt + int'(mt)) < 4));
            sent  = sent + int'(mt) + int'(at);
            m_cnt = m_cnt + int'(mt) + int'(at) - int'(m_cnt != 0);
            tick();
        end
        idle();
        for (int k = 0; k < 10 && RegWr; k++) tick();
        check("t3_drained", 32'(RegWr), 32'd0);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Illegal address consumed, pulses bad_addr once, never queued
        set_alu(1'b1, 5'd20, 32'h55);
        Raddr1 = 5'd20;
        #1;
        check("t4_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("t4_bad_pulse", 32'(bad_addr), 32'd1);
        check("t4_regwr", 32'(RegWr), 32'd0);
        check("t4_hit1", 32'(fwd_hit1), 32'd0);
        tick();
        check("t4_bad_clear", 32'(bad_addr), 32'd0);
        check("t4_regwr2", 32'(RegWr), 32'd0);
        set_mem(1'b1, 5'd16, 32'h66);
        set_alu(1'b1, 5'd31, 32'h77);
        #1;
        check("t4_dual_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("t4_dual_bad_pulse", 32'(bad_addr), 32'd1);
        check("t4_dual_regwr", 32'(RegWr), 32'd0);
        tick();
        check("t4_dual_bad_clear", 32'(bad_addr), 32'd0);
        Raddr1 = 5'd0;

        // Wrap-around: pairs pushed and drained repeatedly
        for (int k = 0; k < 6; k++) begin
            set_mem(1'b1, 5'(2 * k), 32'h5000 + 2 * k);
            set_alu(1'b1, 5'(2 * k + 1), 32'h5001 + 2 * k);
            expect_wr(5'(2 * k), 32'h5000 + 2 * k);
            expect_wr(5'(2 * k + 1), 32'h5001 + 2 * k);
            tick();
            idle();
            tick();
            tick();
        end
        check("t5_idle", 32'(RegWr), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation discards queued entries and same-cycle input
        set_mem(1'b1, 5'd1, 32'h6001);
        set_alu(1'b1, 5'd2, 32'h6002);
        expect_wr(5'd1, 32'h6001);
        tick();
        set_mem(1'b1, 5'd3, 32'h6003);
        set_alu(1'b1, 5'd4, 32'h6004);
        tick();
        idle();
        Raddr2 = 5'd4;
        #1;
        check("t6_hit2", 32'(fwd_hit2), 32'd1);
        check("t6_fdata2", fwd_data2, 32'h6004);
        RESET = 1'b1;
        set_alu(1'b1, 5'd9, 32'h6009);
        tick();
        RESET = 1'b0;
        idle();
        exp_q.delete();
        #1;
        check("t6_regwr0", 32'(RegWr), 32'd0);
        check("t6_hit2_cleared", 32'(fwd_hit2), 32'd0);
        tick();
        check("t6_regwr1", 32'(RegWr), 32'd0);
        Raddr2 = 5'd0;

        repeat (3) tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered writer for the 16-entry, 32-bit general-purpose register file. It accepts results from the ALU and the load unit, queues them in order, and drains at most one write per cycle into the register file's `RegWr`/`Waddr`/`Writedata` port. It also forwards queued-but-unwritten values to the decode stage's two read addresses, so decode never sees stale data.

## Interface
Parameters:
- `DEPTH`, default 4: number of queue entries. Must be a power of 2, at least 2.

Ports:
- `CLK`, in, 1: single clock. All state updates on the rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `mem_valid`, in, 1: load result present this cycle.
- `mem_addr`, in, 5: destination register of the load result.
- `mem_data`, in, 32: load result data.
- `mem_ready`, out, 1: queue can accept the load result.
- `alu_valid`, in, 1: ALU result present this cycle.
- `alu_addr`, in, 5: destination register of the ALU result.
- `alu_data`, in, 32: ALU result data.
- `alu_ready`, out, 1: queue can accept the ALU result.
- `RegWr`, out, 1: write strobe to the register file.
- `Waddr`, out, 5: write address to the register file.
- `Writedata`, out, 32: write data to the register file.
- `Raddr1`, in, 5: decode read address 1 (forwarding lookup).
- `Raddr2`, in, 5: decode read address 2 (forwarding lookup).
- `fwd_hit1`, out, 1: a queued entry matches `Raddr1`.
- `fwd_data1`, out, 32: data of the youngest entry matching `Raddr1`.
- `fwd_hit2`, out, 1: a queued entry matches `Raddr2`.
- `fwd_data2`, out, 32: data of the youngest entry matching `Raddr2`.
- `bad_addr`, out, 1: registered one-cycle pulse when an accepted request had address ≥ 16.

## Operation
- **Storage.** Circular buffer of `{addr[3:0], data[31:0]}` entries.
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` runs 0..DEPTH.
- **Handshake.** A source transfers on `valid && ready` at the rising edge.
  - `space = DEPTH - count`, using registered count only. There is no combinational path from this cycle's pop to ready.
  - `mem_ready = (space >= 1)`.
  - `alu_ready = (space >= 1 + mem_take)`, where `mem_take = mem_valid && mem_ready && !mem_addr[4]`.
- **Ordering.** If both sources transfer in the same cycle, the mem entry is enqueued first and the ALU entry second, because the load is the older instruction.
- **Illegal addresses.** A transfer with `addr[4]=1` is consumed: the source's ready is honoured. It is not enqueued, and `bad_addr` pulses the next cycle. If both sources are illegal in the same cycle, there is still a single pulse.
- **Drain.**
  - `RegWr = (count != 0)`.
  - `Waddr = {1'b0, head.addr}` and `Writedata = head.data`.
  - When empty, `Waddr` and `Writedata` are 0.
  - Each rising edge with `RegWr=1` pops the head. The register file consumes unconditionally.
- **Count update.** `count_next = count + pushes(0..2) - pop`. Simultaneous push and pop is legal, including at full and at empty.
  - A push into an empty queue becomes visible on `RegWr` the next cycle. There is no bypass.
- **Forwarding.** Combinational over the valid entries, i.e. those from the read pointer up to the write pointer.
  - `fwd_hitN = 1` if any entry's addr equals `RaddrN[3:0]` and `RaddrN[4]=0`.
  - `fwd_dataN` is the data of the youngest such entry; it is 0 on a miss.
  - The head entry being drained this cycle still counts as a hit.
  - Same-cycle incoming requests are not forwarded.
- **Reset.** Active-high and synchronous. It clears the pointers, count and `bad_addr`.
  - Queued entries are discarded and never written.
  - Inputs presented during the reset cycle are ignored.
  - Entry data storage need not be reset.

## Timing
- Reset values: `RegWr=0`, `Waddr=0`, `Writedata=0`, `fwd_hit1=0`, `fwd_hit2=0`, `fwd_data1=0`, `fwd_data2=0`, `bad_addr=0`. After reset, `mem_ready=1`, and `alu_ready=1` whenever DEPTH ≥ 2.
- Latency from accept to `RegWr` is 1 cycle when the queue is empty. Otherwise it is 1 + the number of entries ahead.
- Throughput is one register write per cycle. The steady-state input rate is one result per cycle.
- Every output except `bad_addr` is a combinational decode of registered state plus `Raddr*` and `mem_valid`/`mem_addr`.
- Both ready outputs are stable early in the cycle; they depend only on `count`, `mem_valid` and `mem_addr`.

## Structure
- Package `regfile_pkg` holds:
  - `NUM_REGS=16`, `DATA_W=32`, `RADDR_W=5`, `RIDX_W=4`;
  - the typedef `wq_entry_t {logic [3:0] addr; logic [31:0] data;}`.
- Sub-module `wq_fwd_lookup` holds the youngest-match priority search over the entries. Given the entries, read pointer, count and a lookup address, it returns hit and data. It is instantiated twice, once per read port.

## Test plan
- **Reset then single write.** Release reset; push ALU (addr 3, 0xDEADBEEF). The next cycle shows `RegWr=1`, `Waddr=3`, `Writedata=0xDEADBEEF`; the cycle after shows `RegWr=0`.
- **Dual push ordering.** Same cycle: mem (5, 0x11) and ALU (5, 0x22). Drains 5←0x11, then 5←0x22. During the first drain cycle, `Raddr1=5` gives `fwd_hit1=1`, `fwd_data1=0x22`.
- **Full and backpressure (DEPTH=4).** Hold the ALU valid every cycle from empty, with no mem traffic. `alu_ready` never drops, since one entry drains per cycle. Then present dual pushes each cycle: the queue fills to 4, `alu_ready` drops at count ≥ 3, `mem_ready` drops at count = 4, and no entry is lost or duplicated. Write 10 entries; the drain order matches a scoreboard.
- **Illegal address.** ALU push of addr 20 with data 0x55 is accepted. `bad_addr` pulses for exactly one cycle, `RegWr` stays 0, and `fwd_hit` stays 0 for `Raddr1=20`.
- **Wrap-around.** Push 2 entries and drain them, 6 times in a row. The pointers wrap, and all 12 writes appear in order with correct data.
- **Reset mid-operation.** Fill 3 entries, assert `RESET` for one cycle. `RegWr=0` for 2 cycles afterwards, and the discarded addresses are never written.
